// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: captures decoded operands and control into Execute,
// forwards ALU operands from Memory/Writeback, and flags load-use hazards.
module decode_execute_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  WA3D,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [1:0]       FlagWriteD,
  input  logic [3:0]       CondD,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [RA_W-1:0]  WA3M,
  input  logic [RA_W-1:0]  WA3W,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [RA_W-1:0]  RA1E,
  output logic [RA_W-1:0]  RA2E,
  output logic [RA_W-1:0]  WA3E,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             MemtoRegE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic             ValidE,
  output logic [1:0]       ALUControlE,
  output logic [1:0]       FlagWriteE,
  output logic [3:0]       CondE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic             LdStallD
);

  localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

  // Reset and flush both leave a clean bubble; flush beats stall.
  always_ff @(posedge CLK) begin
    if (RESET || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ValidE      <= 1'b0;
      ALUControlE <= 2'b00;
      FlagWriteE  <= 2'b00;
      CondE       <= 4'h0;
    end else if (!StallE) begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
      WA3E        <= WA3D;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      MemtoRegE   <= MemtoRegD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ValidE      <= ValidD;
      ALUControlE <= ALUControlD;
      FlagWriteE  <= FlagWriteD;
      CondE       <= CondD;
    end
  end

  // Memory wins over Writeback; R15 already carries PC+8 so it is never bypassed.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (ValidE && RA1E != PC_REG) begin
      if (RegWriteM && WA3M == RA1E)      ForwardAE = 2'b10;
      else if (RegWriteW && WA3W == RA1E) ForwardAE = 2'b01;
    end
    if (ValidE && RA2E != PC_REG) begin
      if (RegWriteM && WA3M == RA2E)      ForwardBE = 2'b10;
      else if (RegWriteW && WA3W == RA2E) ForwardBE = 2'b01;
    end
  end

  always_comb begin
    SrcAE = RD1E;
    unique case (ForwardAE)
      2'b10:   SrcAE = ALUResultM;
      2'b01:   SrcAE = ResultW;
      default: SrcAE = RD1E;
    endcase
    WriteDataE = RD2E;
    unique case (ForwardBE)
      2'b10:   WriteDataE = ALUResultM;
      2'b01:   WriteDataE = ResultW;
      default: WriteDataE = RD2E;
    endcase
  end

  // A load in Execute feeding the instruction in Decode cannot be bypassed in time.
  always_comb begin
    LdStallD = ValidE && MemtoRegE && RegWriteE && (WA3E != PC_REG) && ValidD &&
               ((WA3E == RA1D) || (WA3E == RA2D));
  end

endmodule
